// File: rtl/demux_1x4_stream_if.sv
// demux_1x4_stream_if
//   Bundles the stream-side signals of demux_1x4_stream: one valid/ready
//   input stream with its routing controls, four valid/ready output channels
//   and the status outputs (round-robin pointer, accepted-word counter).
//
//   Signals
//     in_data   [WIDTH]    input word
//     in_sel    [2]        target channel when rr_mode=0
//     in_valid             input word present
//     in_ready             demux can take the word this cycle
//     rr_mode              1: round-robin routing, 0: route by in_sel
//     out_data  [4*WIDTH]  channel k at [k*WIDTH +: WIDTH]
//     out_valid [4]        channel k holds a word
//     out_ready [4]        channel k consumer takes the word
//     rr_ptr    [2]        current round-robin pointer
//     acc_count [CNT_W]    accepted-word counter, wraps
//
//   Modports
//     slave  : the demux itself
//     master : the environment driving the input and consuming the channels
interface demux_1x4_stream_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic [WIDTH-1:0]   in_data;
    logic [1:0]         in_sel;
    logic               in_valid;
    logic               in_ready;
    logic               rr_mode;
    logic [4*WIDTH-1:0] out_data;
    logic [3:0]         out_valid;
    logic [3:0]         out_ready;
    logic [1:0]         rr_ptr;
    logic [CNT_W-1:0]   acc_count;

    modport slave (
        input  in_data,
        input  in_sel,
        input  in_valid,
        input  rr_mode,
        input  out_ready,
        output in_ready,
        output out_data,
        output out_valid,
        output rr_ptr,
        output acc_count
    );

    modport master (
        output in_data,
        output in_sel,
        output in_valid,
        output rr_mode,
        output out_ready,
        input  in_ready,
        input  out_data,
        input  out_valid,
        input  rr_ptr,
        input  acc_count
    );
endinterface

// File: rtl/demux_1x4_stream.sv
// demux_1x4_stream
//   Registered 1-to-4 stream demultiplexer. A single valid/ready input
//   stream is routed to one of four output channels, chosen either by an
//   explicit select or by an internal round-robin pointer. Every channel owns
//   a one-entry holding register, so a stalled channel only blocks words
//   aimed at it; traffic for the other channels keeps flowing.
//
//   Ports
//     clk  : clock, all state changes on the rising edge
//     rst  : synchronous reset, active-high
//     bus  : demux_1x4_stream_if.slave (input stream, four output channels,
//            rr_ptr and acc_count status)
//
//   Parameters
//     WIDTH : data width per word (must match the interface)
//     CNT_W : width of the accepted-word counter (must match the interface)
module demux_1x4_stream #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    demux_1x4_stream_if.slave      bus
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [3:0][WIDTH-1:0] data_q;
    logic [3:0][WIDTH-1:0] data_d;
    logic [3:0]            valid_q;
    logic [3:0]            valid_d;
    logic [1:0]            rr_ptr_q;
    logic [1:0]            rr_ptr_d;
    logic [CNT_W-1:0]      acc_count_q;
    logic [CNT_W-1:0]      acc_count_d;

    // ------------------------------------------------------------------
    // Routing and handshake
    // ------------------------------------------------------------------
    logic [1:0] target;
    logic       in_ready;
    logic       accept;
    logic [3:0] load;

    // Target follows rr_mode combinationally, so a mode change redirects the
    // word presented in that very cycle.
    always_comb begin
        target = bus.rr_mode ? rr_ptr_q : bus.in_sel;
    end

    // A full channel can still take a word when its consumer drains in the
    // same cycle; this is what gives one word per cycle per channel.
    always_comb begin
        in_ready = ~valid_q[target] | bus.out_ready[target];
        accept   = bus.in_valid & in_ready;
    end

    // ------------------------------------------------------------------
    // Per-channel holding registers
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_chan
            always_comb begin
                load[gi]    = accept && (target == 2'(gi));
                valid_d[gi] = valid_q[gi];
                data_d[gi]  = data_q[gi];
                if (load[gi]) begin
                    // Load wins over drain: the new word replaces the old
                    // one and valid stays set, no bubble.
                    valid_d[gi] = 1'b1;
                    data_d[gi]  = bus.in_data;
                end else if (valid_q[gi] && bus.out_ready[gi]) begin
                    // Drain clears only the flag; data keeps its last value.
                    valid_d[gi] = 1'b0;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_q[gi] <= 1'b0;
                    data_q[gi]  <= '0;
                end else begin
                    valid_q[gi] <= valid_d[gi];
                    data_q[gi]  <= data_d[gi];
                end
            end

            // A stalled channel must present a stable word.
            a_stall_stable: assert property (
                @(posedge clk) disable iff (rst)
                (valid_q[gi] && !bus.out_ready[gi])
                    |=> (valid_q[gi] && (data_q[gi] == $past(data_q[gi])))
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Round-robin pointer and accepted-word counter
    // ------------------------------------------------------------------
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        acc_count_d = acc_count_q;
        if (accept) begin
            acc_count_d = acc_count_q + CNT_W'(1);
            // The pointer only advances when it actually chose the target.
            if (bus.rr_mode) begin
                rr_ptr_d = rr_ptr_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q    <= 2'd0;
            acc_count_q <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            acc_count_q <= acc_count_d;
        end
    end

    // At most one channel is loaded per cycle.
    a_single_load: assert property (
        @(posedge clk) disable iff (rst) $onehot0(load)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Packed [3:0][WIDTH-1:0] places channel k at [k*WIDTH +: WIDTH].
    assign bus.out_data  = data_q;
    assign bus.out_valid = valid_q;
    assign bus.in_ready  = in_ready;
    assign bus.rr_ptr    = rr_ptr_q;
    assign bus.acc_count = acc_count_q;

endmodule

// File: tb/tb_demux_1x4_stream.sv
module tb_demux_1x4_stream;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic clk;
    logic rst;

    demux_1x4_stream_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    demux_1x4_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct {
        logic       vld;
        logic [1:0] sel;
        logic       rr;
        logic [7:0] din;
        logic [3:0] ordy;
        logic       exp_rdy;
        logic [3:0] exp_v;
        logic [1:0] exp_rr;
        logic [3:0] exp_acc;
        logic [1:0] chk_ch;
        logic [7:0] exp_d;
    } vec_t;

    vec_t vecs[24];

    function automatic vec_t mk(logic vld, logic [1:0] sel, logic rr, logic [7:0] din,
                                logic [3:0] ordy, logic exp_rdy, logic [3:0] exp_v,
                                logic [1:0] exp_rr, logic [3:0] exp_acc,
                                logic [1:0] chk_ch, logic [7:0] exp_d);
        vec_t v;
        v.vld = vld; v.sel = sel; v.rr = rr; v.din = din; v.ordy = ordy;
        v.exp_rdy = exp_rdy; v.exp_v = exp_v; v.exp_rr = exp_rr;
        v.exp_acc = exp_acc; v.chk_ch = chk_ch; v.exp_d = exp_d;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    function automatic logic [7:0] ch_data(input logic [1:0] k);
        logic [4*WIDTH-1:0] flat;
        flat = bus.out_data;
        return flat[k*WIDTH +: WIDTH];
    endfunction

    task automatic drive(input logic vld, input logic [1:0] sel, input logic rr,
                         input logic [7:0] din, input logic [3:0] ordy);
        bus.in_valid  = vld;
        bus.in_sel    = sel;
        bus.rr_mode   = rr;
        bus.in_data   = din;
        bus.out_ready = ordy;
    endtask

    // Apply one vector: check in_ready before the edge, registered state after.
    task automatic step(input vec_t v, input int idx);
        drive(v.vld, v.sel, v.rr, v.din, v.ordy);
        #1;
        chk($sformatf("v%0d in_ready", idx), 32'(bus.in_ready), 32'(v.exp_rdy));
        @(posedge clk);
        #1;
        chk($sformatf("v%0d out_valid", idx), 32'(bus.out_valid), 32'(v.exp_v));
        chk($sformatf("v%0d rr_ptr", idx), 32'(bus.rr_ptr), 32'(v.exp_rr));
        chk($sformatf("v%0d acc_count", idx), 32'(bus.acc_count), 32'(v.exp_acc));
        chk($sformatf("v%0d ch%0d data", idx, v.chk_ch), 32'(ch_data(v.chk_ch)), 32'(v.exp_d));
        $display("vec %0d: vld=%0b sel=%0d rr=%0b din=%02h ordy=%04b -> ovalid=%04b rr_ptr=%0d acc=%0d",
                 idx, v.vld, v.sel, v.rr, v.din, v.ordy, bus.out_valid, bus.rr_ptr, bus.acc_count);
    endtask

    initial begin
        // Select mode, all ready
        vecs[0]  = mk(1, 0, 0, 8'hA0, 4'b1111, 1, 4'b0001, 0, 1, 0, 8'hA0);
        vecs[1]  = mk(1, 1, 0, 8'hA1, 4'b1111, 1, 4'b0010, 0, 2, 1, 8'hA1);
        vecs[2]  = mk(1, 2, 0, 8'hA2, 4'b1111, 1, 4'b0100, 0, 3, 2, 8'hA2);
        vecs[3]  = mk(1, 3, 0, 8'hA3, 4'b1111, 1, 4'b1000, 0, 4, 3, 8'hA3);
        vecs[4]  = mk(0, 3, 0, 8'hFF, 4'b1111, 1, 4'b0000, 0, 4, 3, 8'hA3);
        // Backpressure on ch2
        vecs[5]  = mk(1, 2, 0, 8'h55, 4'b1011, 1, 4'b0100, 0, 5, 2, 8'h55);
        vecs[6]  = mk(1, 2, 0, 8'h77, 4'b1011, 0, 4'b0100, 0, 5, 2, 8'h55);
        vecs[7]  = mk(1, 1, 0, 8'h66, 4'b1011, 1, 4'b0110, 0, 6, 1, 8'h66);
        vecs[8]  = mk(0, 0, 0, 8'h00, 4'b1001, 1, 4'b0110, 0, 6, 2, 8'h55);
        vecs[9]  = mk(0, 0, 0, 8'h00, 4'b1111, 1, 4'b0000, 0, 6, 1, 8'h66);
        // Simultaneous drain and load on ch0
        vecs[10] = mk(1, 0, 0, 8'h11, 4'b1111, 1, 4'b0001, 0, 7, 0, 8'h11);
        vecs[11] = mk(1, 0, 0, 8'h22, 4'b0001, 1, 4'b0001, 0, 8, 0, 8'h22);
        vecs[12] = mk(0, 0, 0, 8'h00, 4'b0000, 0, 4'b0001, 0, 8, 0, 8'h22);
        vecs[13] = mk(0, 0, 0, 8'h00, 4'b1111, 1, 4'b0000, 0, 8, 0, 8'h22);
        // Round-robin, in_sel=3 must be ignored
        vecs[14] = mk(1, 3, 1, 8'h01, 4'b1111, 1, 4'b0001, 1, 9,  0, 8'h01);
        vecs[15] = mk(1, 3, 1, 8'h02, 4'b1111, 1, 4'b0010, 2, 10, 1, 8'h02);
        vecs[16] = mk(1, 3, 1, 8'h03, 4'b1111, 1, 4'b0100, 3, 11, 2, 8'h03);
        vecs[17] = mk(1, 3, 1, 8'h04, 4'b1111, 1, 4'b1000, 0, 12, 3, 8'h04);
        vecs[18] = mk(1, 3, 1, 8'h05, 4'b1111, 1, 4'b0001, 1, 13, 0, 8'h05);
        vecs[19] = mk(1, 3, 1, 8'h06, 4'b1111, 1, 4'b0010, 2, 14, 1, 8'h06);
        // Fill ch2 in select mode (pointer holds), then stall rr on ch2
        vecs[20] = mk(1, 2, 0, 8'h77, 4'b1011, 1, 4'b0100, 2, 15, 2, 8'h77);
        vecs[21] = mk(1, 0, 1, 8'h88, 4'b1011, 0, 4'b0100, 2, 15, 2, 8'h77);
        // Stall released: drain+load on ch2, counter wraps to 0 (16th accept)
        vecs[22] = mk(1, 0, 1, 8'h88, 4'b1111, 1, 4'b0100, 3, 0,  2, 8'h88);
        vecs[23] = mk(0, 0, 1, 8'h00, 4'b1111, 1, 4'b0000, 3, 0,  2, 8'h88);

        // Reset held 2 cycles with a valid word offered
        rst = 1'b1;
        drive(1, 0, 0, 8'hEE, 4'b0000);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset out_valid", 32'(bus.out_valid), 32'h0);
        chk("reset out_data", bus.out_data, 32'h0);
        chk("reset rr_ptr", 32'(bus.rr_ptr), 32'h0);
        chk("reset acc_count", 32'(bus.acc_count), 32'h0);
        $display("reset: ovalid=%04b rr_ptr=%0d acc=%0d", bus.out_valid, bus.rr_ptr, bus.acc_count);

        for (int i = 0; i < 24; i++) begin
            step(vecs[i], i);
        end

        // Fill all four channels with consumers stalled
        for (int k = 0; k < 4; k++) begin
            drive(1, 2'(k), 0, 8'hC0 + 8'(k), 4'b0000);
            @(posedge clk);
            #1;
            $display("fill ch%0d: ovalid=%04b", k, bus.out_valid);
        end
        chk("full out_valid", 32'(bus.out_valid), 32'hF);
        chk("full acc_count", 32'(bus.acc_count), 32'd4);
        for (int k = 0; k < 4; k++) begin
            drive(1, 2'(k), 0, 8'h99, 4'b0000);
            #1;
            chk($sformatf("full in_ready sel%0d", k), 32'(bus.in_ready), 32'h0);
        end
        drive(1, 0, 1, 8'h99, 4'b0000);
        #1;
        chk("full in_ready rr", 32'(bus.in_ready), 32'h0);
        chk("full ch3 data", 32'(ch_data(2'd3)), 32'hC3);

        // Mid-operation reset pulse with a word still offered
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1, 1, 0, 8'h99, 4'b0000);
        #1;
        chk("midrst out_valid", 32'(bus.out_valid), 32'h0);
        chk("midrst in_ready", 32'(bus.in_ready), 32'h1);
        chk("midrst acc_count", 32'(bus.acc_count), 32'h0);
        chk("midrst rr_ptr", 32'(bus.rr_ptr), 32'h0);
        $display("mid reset: ovalid=%04b in_ready=%0b", bus.out_valid, bus.in_ready);

        // Counter wrap: 16 round-robin words, all ready
        for (int n = 1; n <= 16; n++) begin
            drive(1, 0, 1, 8'(n), 4'b1111);
            @(posedge clk);
            #1;
            $display("wrap word %0d: acc=%0d rr_ptr=%0d", n, bus.acc_count, bus.rr_ptr);
            if (n == 15) begin
                chk("wrap acc at 15", 32'(bus.acc_count), 32'd15);
            end
        end
        chk("wrap acc at 16", 32'(bus.acc_count), 32'd0);
        chk("wrap rr_ptr", 32'(bus.rr_ptr), 32'd0);
        chk("wrap last data ch3", 32'(ch_data(2'd3)), 32'h10);

        drive(0, 0, 0, 8'h00, 4'b1111);
        @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
